// File: rtl/srl_fifo_reader_if.sv
// Valid/ready bus for the SRL-backed FIFO: write side (I_*), read side (O_*) and occupancy.
// A transfer happens on a side when its VALID and READY are both high at the active clock edge.
interface srl_fifo_reader_if #(
  parameter int WIDTH = 8
);
  logic             I_VALID;
  logic             I_READY;
  logic [WIDTH-1:0] I_DATA;
  logic             O_VALID;
  logic             O_READY;
  logic [WIDTH-1:0] O_DATA;
  logic [4:0]       COUNT;

  modport master (
    output I_VALID, I_DATA, O_READY,
    input  I_READY, O_VALID, O_DATA, COUNT
  );

  modport slave (
    input  I_VALID, I_DATA, O_READY,
    output I_READY, O_VALID, O_DATA, COUNT
  );
endinterface

// File: rtl/srl_fifo_reader.sv
// Shallow FIFO on 16-tap shift-register storage: writes shift in at tap 0 and the oldest
// entry is read through tap COUNT-1, the way an SRL16 is addressed.
module srl_fifo_reader #(
  parameter int WIDTH           = 8,
  parameter int DEPTH           = 16,
  parameter bit IS_CLK_INVERTED = 1'b0
) (
  input logic              CLK,
  input logic              RST,
  srl_fifo_reader_if.slave bus
);

  logic             clk_act;
  logic [WIDTH-1:0] r [16];
  logic [4:0]       count;
  logic [3:0]       addr;
  logic             i_ready;
  logic             o_valid;
  logic             push;
  logic             pop;

  // Falling-edge operation is obtained by inverting the clock seen by every register.
  assign clk_act = CLK ^ IS_CLK_INVERTED;

  assign i_ready = (count < 5'(DEPTH));
  assign o_valid = (count != 5'd0);
  assign push    = bus.I_VALID & i_ready;
  assign pop     = o_valid & bus.O_READY;
  assign addr    = count[3:0] - 4'd1;

  assign bus.I_READY = i_ready;
  assign bus.O_VALID = o_valid;
  assign bus.O_DATA  = o_valid ? r[addr] : '0;
  assign bus.COUNT   = count;

  // Storage has no reset; entries beyond COUNT are masked off the output.
  always_ff @(posedge clk_act) begin
    if (push) begin
      r[0] <= bus.I_DATA;
      for (int k = 1; k < 16; k++) begin
        r[k] <= r[k-1];
      end
    end
  end

  always_ff @(posedge clk_act) begin
    if (RST) begin
      count <= 5'd0;
    end else if (push && !pop) begin
      count <= count + 5'd1;
    end else if (!push && pop) begin
      count <= count - 5'd1;
    end
  end

endmodule

// File: tb/tb_srl_fifo_reader.sv
// Bench for srl_fifo_reader: a queue model checked every cycle on both a rising-edge and a
// falling-edge instance, plus directed scenarios with literal expectations.
module tb_srl_fifo_reader;

  localparam int WIDTH = 8;
  localparam int DEPTH = 16;

  logic             CLK = 1'b0;
  logic             rst = 1'b1;
  logic             i_valid = 1'b0;
  logic [WIDTH-1:0] i_data = '0;
  logic             o_ready = 1'b0;
  int               phase = 0;

  int tests = 0;
  int fails = 0;

  logic [WIDTH-1:0] exp_q[$];

  srl_fifo_reader_if #(.WIDTH(WIDTH)) bus0 ();
  srl_fifo_reader_if #(.WIDTH(WIDTH)) bus1 ();

  assign bus0.I_VALID = i_valid;
  assign bus0.I_DATA  = i_data;
  assign bus0.O_READY = o_ready;
  assign bus1.I_VALID = i_valid;
  assign bus1.I_DATA  = i_data;
  assign bus1.O_READY = o_ready;

  srl_fifo_reader #(.WIDTH(WIDTH), .DEPTH(DEPTH), .IS_CLK_INVERTED(1'b0)) dut0 (
    .CLK(CLK), .RST(rst), .bus(bus0)
  );
  srl_fifo_reader #(.WIDTH(WIDTH), .DEPTH(DEPTH), .IS_CLK_INVERTED(1'b1)) dut1 (
    .CLK(CLK), .RST(rst), .bus(bus1)
  );

  logic             s_i_ready;
  logic             s_o_valid;
  logic [WIDTH-1:0] s_o_data;
  logic [4:0]       s_count;

  assign s_i_ready = (phase == 1) ? bus1.I_READY : bus0.I_READY;
  assign s_o_valid = (phase == 1) ? bus1.O_VALID : bus0.O_VALID;
  assign s_o_data  = (phase == 1) ? bus1.O_DATA  : bus0.O_DATA;
  assign s_count   = (phase == 1) ? bus1.COUNT   : bus0.COUNT;

  // clock / reset
  always #5 CLK = ~CLK;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] req);
    tests++;
    if (act !== req) begin
      fails++;
      $display("FAIL %s phase=%0d actual=%0h required=%0h", name, phase, act, req);
    end
  endtask

  // Wait for the active edge of the instance under test, then step off it.
  task automatic tick();
    if (phase == 1) @(negedge CLK); else @(posedge CLK);
    #1;
  endtask

  task automatic compare_model(input string tag);
    logic [WIDTH-1:0] head;
    head = (exp_q.size() != 0) ? exp_q[0] : '0;
    check({tag, "_count"},   64'(s_count),   64'(exp_q.size()));
    check({tag, "_o_valid"}, 64'(s_o_valid), 64'(exp_q.size() != 0));
    check({tag, "_i_ready"}, 64'(s_i_ready), 64'(exp_q.size() < DEPTH));
    check({tag, "_o_data"},  64'(s_o_data),  64'(head));
  endtask

  // scoreboard: model update on the active edge, compare just after it
  always begin
    logic             m_rst, m_iv, m_or, m_push, m_pop;
    logic [WIDTH-1:0] m_id;
    if (phase == 1) @(negedge CLK); else @(posedge CLK);
    m_rst  = rst;
    m_iv   = i_valid;
    m_or   = o_ready;
    m_id   = i_data;
    m_push = m_iv && (exp_q.size() < DEPTH);
    m_pop  = m_or && (exp_q.size() != 0);
    if (m_rst) begin
      exp_q.delete();
    end else begin
      if (m_pop) void'(exp_q.pop_front());
      if (m_push) exp_q.push_back(m_id);
    end
    #2;
    compare_model("edge");
  end

  // Nothing may move on the other clock edge.
  always begin
    if (phase == 1) @(posedge CLK); else @(negedge CLK);
    #2;
    compare_model("offedge");
  end

  task automatic do_reset();
    rst = 1'b1; i_valid = 1'b0; o_ready = 1'b0;
    tick();
    rst = 1'b0;
  endtask

  task automatic push_n(input int n);
    o_ready = 1'b0;
    for (int k = 0; k < n; k++) begin
      i_valid = 1'b1;
      i_data  = WIDTH'($urandom_range(0, 255));
      tick();
    end
    i_valid = 1'b0;
  endtask

  task automatic drain();
    i_valid = 1'b0;
    o_ready = 1'b1;
    for (int k = 0; k < DEPTH + 1; k++) tick();
    o_ready = 1'b0;
  endtask

  task automatic run_suite();
    logic [WIDTH-1:0] seq [6];
    seq[0] = 8'h11; seq[1] = 8'h22; seq[2] = 8'h33;
    seq[3] = 8'h44; seq[4] = 8'h55; seq[5] = 8'h66;

    // reset then fill
    do_reset();
    check("rst_count", 64'(s_count), 64'd0);
    check("rst_i_ready", 64'(s_i_ready), 64'd1);
    check("rst_o_valid", 64'(s_o_valid), 64'd0);
    check("rst_o_data", 64'(s_o_data), 64'd0);
    for (int k = 1; k <= 16; k++) begin
      i_valid = 1'b1;
      i_data  = WIDTH'(k);
      tick();
      check("fill_count", 64'(s_count), 64'(k));
    end
    check("full_i_ready", 64'(s_i_ready), 64'd0);
    i_data = 8'hAA;
    tick();
    check("full_ignore_count", 64'(s_count), 64'd16);
    check("full_ignore_o_data", 64'(s_o_data), 64'h01);

    // drain
    i_valid = 1'b0;
    o_ready = 1'b1;
    for (int k = 1; k <= 16; k++) begin
      check("drain_o_data", 64'(s_o_data), 64'(k));
      tick();
    end
    check("drained_o_valid", 64'(s_o_valid), 64'd0);
    check("drained_o_data", 64'(s_o_data), 64'd0);

    // streaming at COUNT=3
    o_ready = 1'b0;
    for (int j = 0; j < 3; j++) begin
      i_valid = 1'b1; i_data = seq[j]; tick();
    end
    o_ready = 1'b1;
    for (int j = 0; j < 3; j++) begin
      i_data = seq[j+3];
      check("stream_count", 64'(s_count), 64'd3);
      check("stream_o_data", 64'(s_o_data), 64'(seq[j]));
      tick();
    end
    i_valid = 1'b0;
    for (int j = 3; j < 6; j++) begin
      check("stream_tail_o_data", 64'(s_o_data), 64'(seq[j]));
      tick();
    end
    check("stream_end_count", 64'(s_count), 64'd0);

    // push into empty FIFO while consumer is ready
    i_valid = 1'b1; i_data = 8'h5A; o_ready = 1'b1;
    check("empty_same_o_valid", 64'(s_o_valid), 64'd0);
    tick();
    i_valid = 1'b0; o_ready = 1'b0;
    check("empty_next_o_valid", 64'(s_o_valid), 64'd1);
    check("empty_next_o_data", 64'(s_o_data), 64'h5A);
    check("empty_next_count", 64'(s_count), 64'd1);

    // push and pop at COUNT=1: new entry becomes the oldest
    i_valid = 1'b1; i_data = 8'h3C; o_ready = 1'b1;
    tick();
    i_valid = 1'b0; o_ready = 1'b0;
    check("one_pp_count", 64'(s_count), 64'd1);
    check("one_pp_o_data", 64'(s_o_data), 64'h3C);
    drain();

    // full with push and pop together: only the pop happens
    push_n(16);
    i_valid = 1'b1; i_data = 8'hEE; o_ready = 1'b1;
    tick();
    i_valid = 1'b0; o_ready = 1'b0;
    check("full_pp_count", 64'(s_count), 64'd15);
    check("full_pp_i_ready", 64'(s_i_ready), 64'd1);
    drain();

    // reset mid-stream with a push in the same cycle
    push_n(7);
    check("pre_rst_count", 64'(s_count), 64'd7);
    rst = 1'b1; i_valid = 1'b1; i_data = 8'h77;
    tick();
    rst = 1'b0; i_valid = 1'b0;
    check("midrst_count", 64'(s_count), 64'd0);
    check("midrst_o_valid", 64'(s_o_valid), 64'd0);
    check("midrst_i_ready", 64'(s_i_ready), 64'd1);

    // random traffic, biased so the FIFO visits both full and empty
    for (int c = 0; c < 600; c++) begin
      int bias;
      bias    = (c / 100) % 3;
      i_valid = ($urandom_range(0, 3) < (bias == 0 ? 3 : (bias == 1 ? 1 : 2)));
      o_ready = ($urandom_range(0, 3) < (bias == 0 ? 1 : (bias == 1 ? 3 : 2)));
      i_data  = WIDTH'($urandom_range(0, 255));
      rst     = ($urandom_range(0, 79) == 0);
      tick();
    end
    rst = 1'b0; i_valid = 1'b0; o_ready = 1'b0;
    drain();
  endtask

  initial begin
    rst = 1'b1;
    repeat (2) tick();
    run_suite();

    rst = 1'b1; i_valid = 1'b0; o_ready = 1'b0;
    repeat (3) tick();
    phase = 1;
    repeat (3) tick();
    run_suite();

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

// File: doc/srl_fifo_reader.md
Name: srl_fifo_reader

Overview:
- Synchronous FIFO built on addressable shift-register storage: 16 x WIDTH.
- Writes shift data in at tap 0. The read side tracks occupancy and selects the oldest entry through the tap address, the same way an SRL16 is read.
- Used as a shallow elastic buffer between valid/ready stages in xc7 SRL tests and small datapaths. It is the consumer (reader) counterpart of a plain SRL-based shifter.

Parameters:
- WIDTH, 8, data width in bits. Legal range 1..64.
- DEPTH, 16, maximum occupancy. Legal range 2..16. The tap address is 4 bits.
- IS_CLK_INVERTED, 1'b0, when 1 all state updates on the falling edge of CLK.

Ports:
- CLK  input  1  clock.
- RST  input  1  synchronous, active-high reset.
- I_VALID  input  1  write request.
- I_READY  output  1  FIFO can accept data; equals (COUNT < DEPTH).
- I_DATA  input  WIDTH  write data.
- O_VALID  output  1  FIFO holds data; equals (COUNT != 0).
- O_READY  input  1  consumer accepts O_DATA this cycle.
- O_DATA  output  WIDTH  oldest entry; 0 when O_VALID=0.
- COUNT  output  5  current occupancy, 0..DEPTH.

Behaviour:
- Clocking and reset:
  - One clock, CLK. The active edge is posedge, or negedge when IS_CLK_INVERTED=1.
  - RST is sampled on the active edge only.
- Storage:
  - Entries are r[0..15], each WIDTH bits. There is no reset on storage.
  - Shift enable is push: r <= {r[14:0], I_DATA}. The newest entry is at index 0.
  - Contents past COUNT are don't-care and must never reach O_DATA.
- Handshake:
  - push = I_VALID & I_READY.
  - pop = O_VALID & O_READY.
- Read tap:
  - addr = COUNT-1 (4 bits).
  - O_DATA = r[addr] combinationally when COUNT != 0, else 0.
  - O_VALID, I_READY and O_DATA depend only on the COUNT register and storage. There is no combinational path from I_VALID or O_READY to any output.
- Occupancy update on each active edge:
  - RST: COUNT <= 0.
  - push & !pop: COUNT <= COUNT+1.
  - !push & pop: COUNT <= COUNT-1.
  - push & pop: COUNT unchanged. The storage still shifts, so the oldest surviving entry lands back at tap COUNT-1.
  - Otherwise: hold.
- Latency: data pushed at edge N is visible on O_DATA with O_VALID=1 after edge N, when the FIFO was empty. Fall-through latency is 1 cycle.
- Reset values: COUNT=0, O_VALID=0, I_READY=1, O_DATA=0.
- Boundary conditions:
  - Full (COUNT=DEPTH): I_READY=0. I_VALID is ignored and storage does not shift. A pop in the same cycle gives COUNT-1, and I_READY rises the next cycle. There is no write-through on a full FIFO.
  - Empty (COUNT=0): O_VALID=0 and O_READY is ignored. A push with O_READY=1 in the same cycle does not pop; the data appears the next cycle.
  - Simultaneous push and pop at COUNT=1: the new entry becomes the oldest and COUNT stays 1.
  - Reset mid-stream: all entries are logically discarded. A push in the same cycle as RST is dropped: COUNT=0 after the edge, even though storage may shift.
  - COUNT never exceeds DEPTH and never underflows. The assertion bench checks 0 <= COUNT <= DEPTH every cycle.
- Ordering: strict FIFO. Output order equals accepted-input order with no duplication or loss.

Test Plan:
- Reset then fill: RST 1 cycle, then push 0x01..0x10 on consecutive cycles with O_READY=0.
  - COUNT climbs 1..16.
  - I_READY=0 after the 16th push.
  - A 17th push of 0xAA is ignored: COUNT stays 16 and O_DATA=0x01.
- Drain: from full, hold O_READY=1 with I_VALID=0.
  - O_DATA sequence is 0x01,0x02,...,0x10, one per cycle.
  - O_VALID=0 and O_DATA=0 after the 16th pop.
- Streaming: COUNT=3 holding 0x11,0x22,0x33; push 0x44,0x55,0x66 with O_READY=1 continuously.
  - COUNT stays 3 while both handshakes fire.
  - O_DATA over the six cycles is 0x11,0x22,0x33,0x44,0x55,0x66.
- Empty edge: COUNT=0, I_VALID=1 with I_DATA=0x5A, O_READY=1.
  - Same cycle: O_VALID=0.
  - Next cycle: O_VALID=1, O_DATA=0x5A, COUNT=1.
- Full edge: COUNT=16, I_VALID=1 and O_READY=1 in the same cycle.
  - Only the pop occurs: COUNT=15 and I_READY=1 next cycle.
  - The pushed value is not stored.
- Reset mid-stream: COUNT=7, assert RST with I_VALID=1.
  - Next cycle: COUNT=0, O_VALID=0, I_READY=1.
  - Repeat the scenarios with IS_CLK_INVERTED=1 and check updates occur on the falling edge only.
